// File: rtl/register_8bit_if.sv
// Byte-serializer bus: wide input word in, registered byte and tally out.
// The master drives the word; the slave (serializer) drives the outputs.
interface register_8bit_if #(
   parameter int DATA_W = 64,
   parameter int BYTE_W = 8
);
   logic [DATA_W-1:0] data_stream;
   logic [BYTE_W-1:0] q;
   logic [7:0]        count;

   modport master (
      output data_stream,
      input  q,
      input  count
   );

   modport slave (
      input  data_stream,
      output q,
      output count
   );
endinterface

// File: rtl/register_8bit.sv
// Byte-serializing register: captures a wide word every NBYTES cycles
// and emits it LSB byte first, one byte per clock, with a wrapping tally.
module register_8bit #(
   parameter int DATA_W = 64,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   register_8bit_if.slave    bus
);
   localparam int NBYTES = DATA_W / BYTE_W;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic [BYTE_W-1:0] q_q, q_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        count_q, count_d;

   // Frame start loads the new word; other slots shift the held word down.
   always_comb begin
      sreg_d  = sreg_q;
      q_d     = q_q;
      idx_d   = idx_q;
      count_d = count_q + 8'd1;
      if (idx_q == '0) begin
         q_d    = bus.data_stream[BYTE_W-1:0];
         sreg_d = bus.data_stream >> BYTE_W;
      end else begin
         q_d    = sreg_q[BYTE_W-1:0];
         sreg_d = sreg_q >> BYTE_W;
      end
      if (idx_q == IDX_LAST) begin
         idx_d = '0;
      end else begin
         idx_d = idx_q + 1'b1;
      end
   end

   // State registers with immediate clear while reset is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg_q  <= '0;
         q_q     <= '0;
         idx_q   <= '0;
         count_q <= '0;
      end else begin
         sreg_q  <= sreg_d;
         q_q     <= q_d;
         idx_q   <= idx_d;
         count_q <= count_d;
      end
   end

   assign bus.q     = q_q;
   assign bus.count = count_q;
endmodule

// File: tb/tb_register_8bit.sv
// Scoreboard bench for the byte serializer: stimulus pushes expected
// bytes/tallies, a monitor pops and compares after every rising edge.
module tb_register_8bit;
   localparam logic [63:0] W = 64'h78677E05F8677E05;

   logic clk;
   logic rst;
   register_8bit_if #(.DATA_W(64), .BYTE_W(8)) bus ();

   register_8bit #(.DATA_W(64), .BYTE_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [7:0] wb [8] = '{8'h05, 8'h7E, 8'h67, 8'hF8,
                          8'h05, 8'h7E, 8'h67, 8'h78};

   logic [15:0] sb[$];
   int total = 0;
   int bad   = 0;
   int edges = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare the DUT outputs just after each rising edge.
   always begin
      logic [15:0] e;
      @(posedge clk);
      #1;
      edges++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (bus.q !== e[15:8]) begin
            bad++;
            $display("FAIL q edge%0d got=%h exp=%h",
                     edges, bus.q, e[15:8]);
         end
         total++;
         if (bus.count !== e[7:0]) begin
            bad++;
            $display("FAIL count edge%0d got=%h exp=%h",
                     edges, bus.count, e[7:0]);
         end
      end
   end

   task automatic step(input logic [63:0] ds, input logic r,
                       input logic [7:0] eq, input logic [7:0] ec);
      @(negedge clk);
      bus.data_stream = ds;
      rst = r;
      sb.push_back({eq, ec});
   endtask

   initial begin
      int k;
      rst = 1'b0;
      bus.data_stream = W;
      #2;
      total++;
      if (bus.q !== 8'h00 || bus.count !== 8'h00) begin
         bad++;
         $display("FAIL reset_init got=%h/%h exp=00/00",
                  bus.q, bus.count);
      end
      // reset hold
      for (int i = 0; i < 60; i++) step(W, 1'b0, 8'h00, 8'h00);
      // serialization frame 1 (edges 1..8)
      for (int i = 1; i <= 8; i++)
         step(W, 1'b1, wb[i-1], 8'(i));
      // frame 2: edges 9,10 then input goes to zero
      step(W, 1'b1, 8'h05, 8'd9);
      step(W, 1'b1, 8'h7E, 8'd10);
      for (int i = 11; i <= 16; i++)
         step(64'h0, 1'b1, wb[i-9], 8'(i));
      // frame 3 captures zero word
      for (int i = 17; i <= 24; i++)
         step(64'h0, 1'b1, 8'h00, 8'(i));
      // back to W through count wrap at edge 256
      for (int i = 25; i <= 256; i++)
         step(W, 1'b1, wb[(i-1)%8], 8'(i % 256));
      // edges 257..261: bytes 0..4 of next frame
      for (int i = 257; i <= 261; i++)
         step(W, 1'b1, wb[(i-1)%8], 8'(i % 256));
      // async reset during byte 4, between edges
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      total++;
      if (bus.q !== 8'h00) begin
         bad++;
         $display("FAIL async_q got=%h exp=00", bus.q);
      end
      total++;
      if (bus.count !== 8'h00) begin
         bad++;
         $display("FAIL async_count got=%h exp=00", bus.count);
      end
      step(W, 1'b0, 8'h00, 8'h00);
      step(W, 1'b0, 8'h00, 8'h00);
      step(W, 1'b1, 8'h05, 8'd1);
      step(W, 1'b1, 8'h7E, 8'd2);
      step(W, 1'b1, 8'h67, 8'd3);
      // drain with a bounded wait
      k = 0;
      while (sb.size() > 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/register_8bit.md
# register_8bit

Byte-serializing register: captures a 64-bit word from `data_stream` at the start of each 8-cycle frame and presents one byte per clock on `q`, least-significant byte first. `count` is a free-running, wrapping tally of bytes emitted since reset. It sits at the front of the averaging datapath and converts a wide sample word into a byte stream for downstream accumulation.

## Interface

Parameters:
- `DATA_W`, default 64: input word width; must be a multiple of `BYTE_W`.
- `BYTE_W`, default 8: output byte width.
- `NBYTES`, derived as `DATA_W/BYTE_W`, default 8: bytes per frame.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `data_stream`  in  DATA_W: word to serialize; sampled only at frame start.
- `q`  out  BYTE_W: current output byte, registered.
- `count`  out  8: bytes emitted since reset, modulo 256, registered.

One clock; reset is asynchronous and active-low.

## Operation

Internal state:
- `sreg[DATA_W-1:0]`: holding shift register.
- `idx`: byte index within the frame, 0..NBYTES-1, width `clog2(NBYTES)`.

While `rst`=0, the asynchronous clear holds `q`=0, `count`=0, `sreg`=0 and `idx`=0.

On each rising edge with `rst`=1:
- If `idx`==0 (frame start):
  - `q` ← `data_stream[BYTE_W-1:0]`.
  - `sreg` ← `data_stream >> BYTE_W`.
- Otherwise:
  - `q` ← `sreg[BYTE_W-1:0]`.
  - `sreg` ← `sreg >> BYTE_W`, zero-filled.
- `idx` ← (`idx`==NBYTES-1) ? 0 : `idx`+1.
- `count` ← `count`+1, wrapping 255→0. There is no saturation or stall.

Rules:
- Byte order is byte0 (bits 7:0) first and byte7 (bits 63:56) last.
- Changes on `data_stream` other than at frame start have no effect on the current frame.
- There is no enable or handshake. The block emits a byte on every clock while out of reset.

## Timing

- Latency: byte0 of the word sampled at edge N appears on `q` immediately after edge N. Byte k appears after edge N+k.
- Frame period: exactly NBYTES (8) cycles. The next capture occurs at edge N+8.
- `count` equals the number of clock edges seen since reset release, mod 256. After the k-th edge, `count`=k mod 256.
- Asynchronous reset assertion mid-frame: `q`, `count`, `idx` and `sreg` clear immediately, with no clock needed.
- Reset release: the first rising edge with `rst`=1 is a frame start. Releasing `rst` coincident with a clock edge is treated as not released for that edge.
- Reset held low indefinitely: outputs stay 0 regardless of clock or `data_stream`.

## Test plan

- Reset hold: `rst`=0 for 60 cycles with `data_stream`=64'h78677E05F8677E05 → `q`=8'h00 and `count`=8'h00 throughout.
- Serialization: release `rst` with the same word → across edges 1..8, `q` = 05, 7E, 67, F8, 05, 7E, 67, 78 and `count` = 1..8. Edge 9 recaptures and gives `q`=05, `count`=9.
- Mid-frame input change: after edge 2 of a frame, change `data_stream` to 64'h0 → bytes 2..7 still come from the original word. The next frame outputs 00 for all 8 bytes.
- Count wrap: run 256 edges after release → `count` reads FF after edge 255 and 00 after edge 256. `q` at edge 256 is byte7 and frame alignment is unchanged.
- Asynchronous reset mid-frame: assert `rst`=0 between edges during byte 4 → `q` and `count` go to 0 without a clock edge. After release, the first edge gives `q`=byte0 and `count`=1.
